// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory port between the
// instruction-fetch and data load/store masters of the CPU.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_writedata,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RESP_I,
        RESP_D
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t      state, state_nx;
    logic        last_grant;
    logic [31:0] lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic        lat_wr;

    logic        i_req, d_req;
    logic        grant_i, grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;
    // On a tie the master that did not win last time is served.
    assign grant_i = (state == IDLE) && i_req && (!d_req || last_grant == OWNER_D);
    assign grant_d = (state == IDLE) && d_req && (!i_req || last_grant == OWNER_I);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= OWNER_D;
            lat_addr   <= '0;
            lat_be     <= '0;
            lat_wdata  <= '0;
            lat_wr     <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant_i) begin
                last_grant <= OWNER_I;
                lat_addr   <= i_address;
                lat_be     <= 4'b1111;
                lat_wdata  <= '0;
                lat_wr     <= 1'b0;
            end else if (grant_d) begin
                last_grant <= OWNER_D;
                lat_addr   <= d_address;
                lat_be     <= d_byteenable;
                lat_wdata  <= d_writedata;
                lat_wr     <= d_write;
            end
        end
    end

    always_comb begin
        state_nx       = state;
        avm_address    = '0;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_byteenable = '0;
        avm_writedata  = '0;
        i_waitrequest  = 1'b1;
        i_readdata     = '0;
        d_waitrequest  = 1'b1;
        d_readdata     = '0;
        unique case (state)
            IDLE: begin
                if (grant_i)      state_nx = GRANT_I;
                else if (grant_d) state_nx = GRANT_D;
            end
            GRANT_I: begin
                avm_address    = lat_addr;
                avm_byteenable = lat_be;
                avm_read       = 1'b1;
                if (!avm_waitrequest) state_nx = RESP_I;
            end
            GRANT_D: begin
                avm_address    = lat_addr;
                avm_byteenable = lat_be;
                avm_writedata  = lat_wdata;
                avm_read       = !lat_wr;
                avm_write      = lat_wr;
                // Writes complete in the accepting cycle; reads need the data phase.
                if (!avm_waitrequest) begin
                    if (lat_wr) begin
                        d_waitrequest = 1'b0;
                        state_nx      = IDLE;
                    end else begin
                        state_nx = RESP_D;
                    end
                end
            end
            RESP_I: begin
                i_waitrequest = 1'b0;
                i_readdata    = avm_readdata;
                state_nx      = IDLE;
            end
            RESP_D: begin
                d_waitrequest = 1'b0;
                d_readdata    = avm_readdata;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a one-cycle registered-read memory model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byteenable;
    logic [31:0] d_writedata;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .i_address       (i_address),
        .i_read          (i_read),
        .i_waitrequest   (i_waitrequest),
        .i_readdata      (i_readdata),
        .d_address       (d_address),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_byteenable    (d_byteenable),
        .d_writedata     (d_writedata),
        .d_waitrequest   (d_waitrequest),
        .d_readdata      (d_readdata),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata)
    );

    // Memory: boot word at 0xBFC00000, elsewhere address ^ 0xA5A50000.
    always @(posedge clk) begin
        if (avm_read && !avm_waitrequest)
            avm_readdata <= (avm_address == 32'hBFC0_0000) ? 32'h1234_5678
                                                            : (avm_address ^ 32'hA5A5_0000);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        i_address = '0; i_read = 1'b0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0;
        d_byteenable = '0; d_writedata = '0;
        avm_waitrequest = 1'b0;
        tick(); tick();
        chk("rst_i_wait", {31'b0, i_waitrequest}, 32'd1);
        chk("rst_d_wait", {31'b0, d_waitrequest}, 32'd1);
        chk("rst_rdwr", {30'b0, avm_read, avm_write}, 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_i_rdata", i_readdata, 32'd0);
        reset = 1'b1;
        tick();

        // Instruction fetch
        i_read = 1'b1; i_address = 32'hBFC0_0000;
        #1 chk("if_c0_read", {31'b0, avm_read}, 32'd0);
        tick();
        chk("if_c1_read", {31'b0, avm_read}, 32'd1);
        chk("if_c1_addr", avm_address, 32'hBFC0_0000);
        chk("if_c1_be", {28'b0, avm_byteenable}, 32'hF);
        chk("if_c1_wait", {31'b0, i_waitrequest}, 32'd1);
        tick();
        chk("if_c2_wait", {31'b0, i_waitrequest}, 32'd0);
        chk("if_c2_data", i_readdata, 32'h1234_5678);
        chk("if_c2_read", {31'b0, avm_read}, 32'd0);
        chk("if_c2_addr", avm_address, 32'd0);
        i_read = 1'b0;
        tick();
        chk("if_c3_wait", {31'b0, i_waitrequest}, 32'd1);
        chk("if_c3_data", i_readdata, 32'd0);

        // Data write with a two-cycle stall
        d_write = 1'b1; d_address = 32'h10; d_byteenable = 4'b0011; d_writedata = 32'hAABB_CCDD;
        avm_waitrequest = 1'b1;
        tick();
        chk("wr_s1_write", {31'b0, avm_write}, 32'd1);
        chk("wr_s1_addr", avm_address, 32'h10);
        chk("wr_s1_be", {28'b0, avm_byteenable}, 32'h3);
        chk("wr_s1_data", avm_writedata, 32'hAABB_CCDD);
        chk("wr_s1_wait", {31'b0, d_waitrequest}, 32'd1);
        tick();
        chk("wr_s2_write", {31'b0, avm_write}, 32'd1);
        chk("wr_s2_data", avm_writedata, 32'hAABB_CCDD);
        chk("wr_s2_wait", {31'b0, d_waitrequest}, 32'd1);
        avm_waitrequest = 1'b0;
        #1 chk("wr_s3_write", {31'b0, avm_write}, 32'd1);
        chk("wr_s3_wait", {31'b0, d_waitrequest}, 32'd0);
        chk("wr_s3_read", {31'b0, avm_read}, 32'd0);
        d_write = 1'b0;
        tick();
        chk("wr_idle_write", {31'b0, avm_write}, 32'd0);
        chk("wr_idle_wait", {31'b0, d_waitrequest}, 32'd1);

        // Latching: address change during GRANT_D is ignored
        d_read = 1'b1; d_address = 32'h20; d_byteenable = 4'b1111; avm_waitrequest = 1'b1;
        tick();
        d_address = 32'h40;
        #1 chk("lat_g1_addr", avm_address, 32'h20);
        chk("lat_g1_read", {31'b0, avm_read}, 32'd1);
        tick();
        chk("lat_g2_addr", avm_address, 32'h20);
        avm_waitrequest = 1'b0;
        #1 chk("lat_g3_addr", avm_address, 32'h20);
        tick();
        chk("lat_resp_wait", {31'b0, d_waitrequest}, 32'd0);
        chk("lat_resp_data", d_readdata, 32'hA5A5_0020);
        d_read = 1'b0;
        tick();
        chk("lat_idle_wait", {31'b0, d_waitrequest}, 32'd1);

        // Read and write together behave as a write
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h30; d_writedata = 32'h0BAD_F00D;
        tick();
        chk("rw_write", {31'b0, avm_write}, 32'd1);
        chk("rw_read", {31'b0, avm_read}, 32'd0);
        chk("rw_wait", {31'b0, d_waitrequest}, 32'd0);
        d_read = 1'b0; d_write = 1'b0;
        tick();
        chk("rw_no_resp", {31'b0, d_waitrequest}, 32'd1);
        chk("rw_idle_rdwr", {30'b0, avm_read, avm_write}, 32'd0);

        // Reset in the middle of GRANT_D
        d_write = 1'b1; d_address = 32'h50; d_writedata = 32'h1111_2222; avm_waitrequest = 1'b1;
        tick();
        chk("rm_pre_write", {31'b0, avm_write}, 32'd1);
        reset = 1'b0;
        #1 chk("rm_write", {31'b0, avm_write}, 32'd0);
        chk("rm_waits", {30'b0, i_waitrequest, d_waitrequest}, 32'd3);
        chk("rm_addr", avm_address, 32'd0);
        d_write = 1'b0; avm_waitrequest = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rm_after_waits", {30'b0, i_waitrequest, d_waitrequest}, 32'd3);
            chk("rm_after_rdwr", {30'b0, avm_read, avm_write}, 32'd0);
        end

        // Simultaneous held requests: I, D, I
        i_read = 1'b1; i_address = 32'hBFC0_0000;
        d_read = 1'b1; d_address = 32'h100;
        tick();
        chk("rr_g1_addr", avm_address, 32'hBFC0_0000);
        chk("rr_g1_read", {31'b0, avm_read}, 32'd1);
        tick();
        chk("rr_r1_iwait", {31'b0, i_waitrequest}, 32'd0);
        chk("rr_r1_idata", i_readdata, 32'h1234_5678);
        chk("rr_r1_dwait", {31'b0, d_waitrequest}, 32'd1);
        tick();
        chk("rr_idle1_rd", {31'b0, avm_read}, 32'd0);
        tick();
        chk("rr_g2_addr", avm_address, 32'h100);
        chk("rr_g2_read", {31'b0, avm_read}, 32'd1);
        tick();
        chk("rr_r2_dwait", {31'b0, d_waitrequest}, 32'd0);
        chk("rr_r2_ddata", d_readdata, 32'hA5A5_0100);
        chk("rr_r2_iwait", {31'b0, i_waitrequest}, 32'd1);
        tick();
        tick();
        chk("rr_g3_addr", avm_address, 32'hBFC0_0000);
        i_read = 1'b0; d_read = 1'b0;
        tick();
        chk("rr_r3_iwait", {31'b0, i_waitrequest}, 32'd0);
        tick();
        chk("rr_end_rdwr", {30'b0, avm_read, avm_write}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
